// File: rtl/vsync_cnt.sv
// Vertical timing stage for 640x480@60 VGA: counts lines on line_end, derives vsync/blanking/frame strobe.
// Optional frame counter output enabled by defining VSYNC_CNT_FRAME_CNT_EN.
module vsync_cnt #(
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_end,
  input  logic       h_rgb_en,
  output logic       vsync,
  output logic       v_rgb_en,
  output logic [9:0] row,
  output logic       disp_en,
  output logic       frame_start
`ifdef VSYNC_CNT_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] ROW_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] ROW_FRONT  = 10'(V_ACTIVE);
  localparam logic [9:0] ROW_SYNC   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] ROW_BACK   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] row_q, row_d;
  logic       vsync_q, vsync_d;
  logic       v_rgb_en_q, v_rgb_en_d;
  logic       frame_start_q, frame_start_d;
  logic [9:0] row_next;
`ifdef VSYNC_CNT_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
`endif

  assign row_next = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;

  // Region transitions look at the row being entered so outputs line up with row.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    frame_start_d = 1'b0;
`ifdef VSYNC_CNT_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q;
`endif
    if (line_end) begin
      row_d = row_next;
      unique case (state_q)
        ACTIVE: if (row_next == ROW_FRONT) state_d = FRONT;
        FRONT:  if (row_next == ROW_SYNC)  state_d = SYNC;
        SYNC:   if (row_next == ROW_BACK)  state_d = BACK;
        BACK:   if (row_next == 10'd0)     state_d = ACTIVE;
        default: state_d = ACTIVE;
      endcase
      if (row_next == 10'd0) begin
        frame_start_d = 1'b1;
`ifdef VSYNC_CNT_FRAME_CNT_EN
        frame_cnt_d   = frame_cnt_q + 8'd1;
`endif
      end
    end
    vsync_d    = (state_d == SYNC) ? SYNC_POL : ~SYNC_POL;
    v_rgb_en_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ACTIVE;
      row_q         <= 10'd0;
      vsync_q       <= ~SYNC_POL;
      v_rgb_en_q    <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef VSYNC_CNT_FRAME_CNT_EN
      frame_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      vsync_q       <= vsync_d;
      v_rgb_en_q    <= v_rgb_en_d;
      frame_start_q <= frame_start_d;
`ifdef VSYNC_CNT_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign row         = row_q;
  assign vsync       = vsync_q;
  assign v_rgb_en    = v_rgb_en_q;
  assign frame_start = frame_start_q;
  assign disp_en     = h_rgb_en & v_rgb_en_q;
`ifdef VSYNC_CNT_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vsync_cnt.sv
// Directed testbench for vsync_cnt: reset, counting, sync window, wrap, hold, back-to-back and mid-frame reset.
module tb_vsync_cnt;

  logic       clk;
  logic       rst;
  logic       line_end;
  logic       h_rgb_en;
  logic       vsync;
  logic       v_rgb_en;
  logic [9:0] row;
  logic       disp_en;
  logic       frame_start;
`ifdef VSYNC_CNT_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int testsRun;
  int testsFailed;

  vsync_cnt dut (
    .clk         (clk),
    .rst         (rst),
    .line_end    (line_end),
    .h_rgb_en    (h_rgb_en),
    .vsync       (vsync),
    .v_rgb_en    (v_rgb_en),
    .row         (row),
    .disp_en     (disp_en),
    .frame_start (frame_start)
`ifdef VSYNC_CNT_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issue n single-cycle line_end pulses; returns on a falling edge just after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) line_end = 1'b1;
      @(negedge clk) line_end = 1'b0;
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst      = 1'b1;
    line_end = 1'b0;
    h_rgb_en = 1'b1;

    // asynchronous reset before the first clock edge
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_row", row, 0);
    checkOutput("reset_vsync", vsync, 1);
    checkOutput("reset_v_rgb_en", v_rgb_en, 1);
    checkOutput("reset_frame_start", frame_start, 0);
    checkOutput("reset_disp_en_h1", disp_en, 1);
    h_rgb_en = 1'b0;
    #1;
    checkOutput("reset_disp_en_h0", disp_en, 0);
    h_rgb_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_hold_row", row, 0);
    rst = 1'b1;

    @(negedge clk);
    checkOutput("release_no_frame_start", frame_start, 0);
    for (int i = 1; i <= 479; i++) begin
      applyStimulus(1);
      checkOutput("active_row", row, i);
      checkOutput("active_v_rgb_en", v_rgb_en, 1);
    end
    checkOutput("active_vsync", vsync, 1);
    h_rgb_en = 1'b0;
    #1 checkOutput("active_disp_en_h0", disp_en, 0);
    h_rgb_en = 1'b1;

    applyStimulus(1);
    checkOutput("front_row480", row, 480);
    checkOutput("front_v_rgb_en", v_rgb_en, 0);
    checkOutput("front_disp_en", disp_en, 0);
    checkOutput("front_vsync", vsync, 1);

    applyStimulus(9);
    checkOutput("front_row489", row, 489);
    checkOutput("front_vsync489", vsync, 1);
    applyStimulus(1);
    checkOutput("sync_row490", row, 490);
    checkOutput("sync_vsync490", vsync, 0);
    applyStimulus(1);
    checkOutput("sync_vsync491", vsync, 0);
    applyStimulus(1);
    checkOutput("back_row492", row, 492);
    checkOutput("back_vsync492", vsync, 1);
    checkOutput("back_v_rgb_en", v_rgb_en, 0);

    applyStimulus(32);
    checkOutput("back_row524", row, 524);
    checkOutput("back_no_frame_start", frame_start, 0);
    applyStimulus(1);
    checkOutput("wrap_row", row, 0);
    checkOutput("wrap_v_rgb_en", v_rgb_en, 1);
    checkOutput("wrap_frame_start", frame_start, 1);
`ifdef VSYNC_CNT_FRAME_CNT_EN
    checkOutput("wrap_frame_cnt", frame_cnt, 1);
`endif
    @(negedge clk);
    checkOutput("wrap_frame_start_clear", frame_start, 0);
    checkOutput("wrap_row_hold", row, 0);

    applyStimulus(10);
    checkOutput("hold_start_row", row, 10);
    repeat (5000) @(negedge clk);
    checkOutput("hold_row", row, 10);

    @(negedge clk) line_end = 1'b1;
    repeat (3) @(negedge clk);
    line_end = 1'b0;
    checkOutput("b2b_row", row, 13);

    applyStimulus(287);
    checkOutput("pre_reset_row", row, 300);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_row", row, 0);
    checkOutput("midreset_vsync", vsync, 1);
    checkOutput("midreset_v_rgb_en", v_rgb_en, 1);
    checkOutput("midreset_disp_en", disp_en, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_hold", row, 0);
    applyStimulus(1);
    checkOutput("post_reset_row1", row, 1);
    checkOutput("post_reset_no_frame_start", frame_start, 0);

    // reset while inside the sync window must deassert vsync immediately
    applyStimulus(489);
    checkOutput("sync2_row490", row, 490);
    checkOutput("sync2_vsync", vsync, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("sync2_reset_vsync", vsync, 1);
    checkOutput("sync2_reset_row", row, 0);
`ifdef VSYNC_CNT_FRAME_CNT_EN
    checkOutput("sync2_reset_frame_cnt", frame_cnt, 0);
`endif
    @(negedge clk) rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
